// File: rtl/kairos_pkg.sv
// kairos_pkg: loader states, configuration word indices and datapath widths shared by io_stream_loader
package kairos_pkg;

    typedef enum logic [1:0] {CFG, INSTR, DATA, DONE} state_e;

    localparam int CFG_INSTR_LAST = 0;
    localparam int CFG_IN_LAST    = 1;
    localparam int CFG_IN_BASE    = 2;
    localparam int CFG_OUT_LAST   = 3;
    localparam int CFG_OUT_BASE   = 4;

    localparam int IO_W   = 16;
    localparam int WORD_W = 32;

endpackage

// File: rtl/io_stream_loader_if.sv
// io_stream_loader_if: pad-side half-word stream plus memory write port of the loader
interface io_stream_loader_if
    import kairos_pkg::*;
#(
    parameter int ADDR_W = 12
);

    logic [IO_W-1:0]   in_data;
    logic              in_vld;
    logic              in_rdy;
    logic              wr_vld;
    logic              wr_rdy;
    logic              wr_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;

    modport master (
        input  in_data, in_vld, wr_rdy,
        output in_rdy, wr_vld, wr_sel, wr_addr, wr_data
    );

    modport slave (
        output in_data, in_vld, wr_rdy,
        input  in_rdy, wr_vld, wr_sel, wr_addr, wr_data
    );

endinterface

// File: rtl/io_stream_loader_halfword_packer.sv
// halfword_packer: joins two 16-bit beats (low half first) into a 32-bit word held in a one-entry write buffer
module halfword_packer
    import kairos_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              beat,
    input  logic [IO_W-1:0]   beat_data,
    input  logic              issue_sel,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wr_rdy,
    output logic              phase,
    output logic              wr_vld,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data
);

    logic              phase_q, phase_d;
    logic [IO_W-1:0]   lo_q, lo_d;
    logic              vld_q, vld_d;
    logic              sel_q, sel_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] data_q, data_d;

    // toggle the half-word phase per beat; the second beat loads the write buffer, which drains on wr_rdy
    always_comb begin
        phase_d = phase_q;
        lo_d    = lo_q;
        vld_d   = vld_q && !wr_rdy;
        sel_d   = sel_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (clear) begin
            phase_d = 1'b0;
        end else if (beat) begin
            phase_d = !phase_q;
            if (!phase_q) begin
                lo_d = beat_data;
            end else begin
                vld_d  = 1'b1;
                sel_d  = issue_sel;
                addr_d = issue_addr;
                data_d = {beat_data, lo_q};
            end
        end
    end

    // buffer registers; reset drops any partial half-word and pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= 1'b0;
            lo_q    <= '0;
            vld_q   <= 1'b0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            phase_q <= phase_d;
            lo_q    <= lo_d;
            vld_q   <= vld_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign phase   = phase_q;
    assign wr_vld  = vld_q;
    assign wr_sel  = sel_q;
    assign wr_addr = addr_q;
    assign wr_data = data_q;

endmodule

// File: rtl/io_stream_loader.sv
// io_stream_loader: loads config words, instructions and input data from a 16-bit pad stream into memory
// Optional: define LOADER_CHECKSUM_EN to add a 32-bit XOR checksum of all written words.
module io_stream_loader
    import kairos_pkg::*;
#(
    parameter int ADDR_W  = 12,
    parameter int NUM_CFG = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart,
    io_stream_loader_if.master bus,
    output logic [IO_W-1:0]    cfg_instr_last,
    output logic [IO_W-1:0]    cfg_in_last,
    output logic [IO_W-1:0]    cfg_in_base,
    output logic [IO_W-1:0]    cfg_out_last,
    output logic [IO_W-1:0]    cfg_out_base,
    output logic               load_done
`ifdef LOADER_CHECKSUM_EN
    ,
    output logic [WORD_W-1:0]  checksum
`endif
);

    state_e            state_q, state_d;
    logic [IO_W-1:0]   cnt_q, cnt_d;
    logic [IO_W-1:0]   cfg_q [NUM_CFG];
    logic [IO_W-1:0]   cfg_d [NUM_CFG];
    logic              alive_q;
    logic              last_q, last_d;
    logic              in_rdy, fire, wr_fire, pack_beat, phase, word_done, restart_ok;
    logic              issue_sel;
    logic [ADDR_W-1:0] issue_addr;

    // alive_q keeps in_rdy low through reset and rises on the first edge after it
    assign in_rdy     = alive_q && (state_q != DONE) && !(bus.wr_vld && !bus.wr_rdy);
    assign bus.in_rdy = in_rdy;
    assign fire       = bus.in_vld && in_rdy;
    assign wr_fire    = bus.wr_vld && bus.wr_rdy;
    assign pack_beat  = fire && (state_q == INSTR || state_q == DATA) && !last_q;
    assign word_done  = pack_beat && phase;
    assign restart_ok = restart && (state_q == DONE);
    assign issue_sel  = state_q == DATA;
    assign issue_addr = issue_sel ? ADDR_W'(cfg_q[CFG_IN_BASE]) + ADDR_W'(cnt_q) : ADDR_W'(cnt_q);

    halfword_packer #(.ADDR_W(ADDR_W)) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (restart_ok),
        .beat       (pack_beat),
        .beat_data  (bus.in_data),
        .issue_sel  (issue_sel),
        .issue_addr (issue_addr),
        .wr_rdy     (bus.wr_rdy),
        .phase      (phase),
        .wr_vld     (bus.wr_vld),
        .wr_sel     (bus.wr_sel),
        .wr_addr    (bus.wr_addr),
        .wr_data    (bus.wr_data)
    );

    // sequencing: config beats, then instruction words, then data words until the last write drains
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        last_d  = last_q;
        if (restart_ok) begin
            state_d = CFG;
            cnt_d   = '0;
            last_d  = 1'b0;
        end else if (state_q == CFG && fire) begin
            for (int k = 0; k < NUM_CFG; k++)
                if (cnt_q == IO_W'(k)) cfg_d[k] = bus.in_data;
            state_d = (cnt_q == IO_W'(NUM_CFG - 1)) ? INSTR : CFG;
            cnt_d   = (cnt_q == IO_W'(NUM_CFG - 1)) ? '0 : cnt_q + 1'b1;
        end else if (state_q == INSTR && word_done) begin
            state_d = (cnt_q == cfg_q[CFG_INSTR_LAST]) ? DATA : INSTR;
            cnt_d   = (cnt_q == cfg_q[CFG_INSTR_LAST]) ? '0 : cnt_q + 1'b1;
        end else if (state_q == DATA && word_done) begin
            last_d = cnt_q == cfg_q[CFG_IN_LAST];
            cnt_d  = last_d ? cnt_q : cnt_q + 1'b1;
        end else if (state_q == DATA && last_q && wr_fire) begin
            state_d = DONE;
            last_d  = 1'b0;
        end
    end

    // control and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CFG;
            cnt_q   <= '0;
            cfg_q   <= '{default: '0};
            alive_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            alive_q <= 1'b1;
            last_q  <= last_d;
        end
    end

    assign cfg_instr_last = cfg_q[CFG_INSTR_LAST];
    assign cfg_in_last    = cfg_q[CFG_IN_LAST];
    assign cfg_in_base    = cfg_q[CFG_IN_BASE];
    assign cfg_out_last   = cfg_q[CFG_OUT_LAST];
    assign cfg_out_base   = cfg_q[CFG_OUT_BASE];
    assign load_done      = state_q == DONE;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] checksum_q, checksum_d;

    // fold in every word the memory takes during INSTR and DATA; restart starts a fresh sum
    always_comb begin
        checksum_d = checksum_q;
        if (restart_ok)
            checksum_d = '0;
        else if (wr_fire && (state_q == INSTR || state_q == DATA))
            checksum_d = checksum_q ^ bus.wr_data;
    end

    // checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) checksum_q <= '0;
        else        checksum_q <= checksum_d;
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_io_stream_loader.sv
// tb_io_stream_loader: randomized loads against a write-list model; honours LOADER_CHECKSUM_EN
module tb_io_stream_loader;

    localparam int AW = 12;

    typedef struct {
        logic [4:0][15:0] cfg;
        bit               ones;
        bit               restart_mid;
        int               rdy_mode;
        logic [11:0]      first_addr;
        logic [11:0]      last_addr;
        int               nwrites;
    } row_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic restart = 1'b0;
    always #5 clk = ~clk;

    io_stream_loader_if #(.ADDR_W(AW)) bus ();

    logic [15:0] cfg_il, cfg_inl, cfg_ib, cfg_ol, cfg_ob;
    logic        load_done;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    io_stream_loader #(.ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .restart        (restart),
        .bus            (bus),
        .cfg_instr_last (cfg_il),
        .cfg_in_last    (cfg_inl),
        .cfg_in_base    (cfg_ib),
        .cfg_out_last   (cfg_ol),
        .cfg_out_base   (cfg_ob),
        .load_done      (load_done)
`ifdef LOADER_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    int   rdy_mode = 0;
    logic rdy_manual = 1'b1;
    logic rdy_rand = 1'b1;
    always @(posedge clk) #1 rdy_rand = ($urandom_range(0, 3) != 0);
    assign bus.wr_rdy = (rdy_mode == 2) ? rdy_manual : (rdy_mode == 1) ? rdy_rand : 1'b1;

    int          checks = 0;
    int          errors = 0;
    logic [44:0] got_q[$];
    int          exp_total = 99999;
    int          beats_acc = 0;
    bit          done_due = 0;
    bit          stall_v = 0;
    bit          chk_rdy = 0;
    logic [44:0] stall_rec;
    logic [15:0] prev_il = '0;
    row_t        rows[4];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic mon_step();
        logic [44:0] cur;
        cur = {bus.wr_sel, bus.wr_addr, bus.wr_data};
        if (!rst_n) begin
            stall_v  = 0;
            done_due = 0;
            return;
        end
        if (stall_v) begin
            check("hold_vld", bus.wr_vld, 1);
            check("hold_word", cur, stall_rec);
        end
        if (chk_rdy) check("in_rdy", bus.in_rdy, !load_done && !(bus.wr_vld && !bus.wr_rdy));
        if (done_due) begin
            check("load_done_rise", load_done, 1);
            done_due = 0;
        end
        if (bus.in_vld && bus.in_rdy) beats_acc++;
        if (bus.wr_vld && bus.wr_rdy) begin
            got_q.push_back(cur);
            if (got_q.size() == exp_total) begin
                check("done_early", load_done, 0);
                done_due = 1;
            end
        end
        stall_v   = bus.wr_vld && !bus.wr_rdy;
        stall_rec = cur;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [15:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        bus.in_data = b;
        bus.in_vld  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.in_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_rdy) check("beat_accept", bus.in_rdy, 1);
        tick();
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!load_done && n < 2000) begin
            tick();
            n++;
        end
        check("load_done_wait", load_done, 1);
    endtask

    function automatic row_t mk_row(input logic [15:0] il, inl, ib, ol, ob, input bit ones, rmid,
                                    input int mode, input logic [11:0] first, last, input int nw);
        row_t r;
        r.cfg         = {ob, ol, ib, inl, il};
        r.ones        = ones;
        r.restart_mid = rmid;
        r.rdy_mode    = mode;
        r.first_addr  = first;
        r.last_addr   = last;
        r.nwrites     = nw;
        return r;
    endfunction

    task automatic run_load(input row_t r);
        logic [31:0] words[$];
        logic [44:0] exp[$];
        logic [31:0] w, xsum;
        int          ni, nd, acc0, n0;
        ni   = int'(r.cfg[0]) + 1;
        nd   = int'(r.cfg[1]) + 1;
        xsum = '0;
        if (load_done) begin
            restart = 1'b1;
            tick();
            restart = 1'b0;
            check("restart_clears_done", load_done, 0);
            check("cfg_retained", cfg_il, prev_il);
        end
        rdy_mode = r.rdy_mode;
        got_q.delete();
        beats_acc = 0;
        for (int i = 0; i < ni + nd; i++) begin
            w = r.ones ? 32'h1 : $urandom();
            if (i == 0 && !r.ones) w = 32'hDEADBEEF;
            words.push_back(w);
            xsum ^= w;
        end
        for (int i = 0; i < ni; i++) exp.push_back({1'b0, 12'(i), words[i]});
        for (int j = 0; j < nd; j++) exp.push_back({1'b1, 12'(int'(r.cfg[2]) + j), words[ni + j]});
        exp_total = ni + nd;
        for (int k = 0; k < 5; k++) send_beat(r.cfg[k], r.rdy_mode != 0);
        check("cfg_instr_last", cfg_il, r.cfg[0]);
        check("cfg_in_last", cfg_inl, r.cfg[1]);
        check("cfg_in_base", cfg_ib, r.cfg[2]);
        check("cfg_out_last", cfg_ol, r.cfg[3]);
        check("cfg_out_base", cfg_ob, r.cfg[4]);
        for (int i = 0; i < ni + nd; i++) begin
            if (r.restart_mid && i == 2) restart = 1'b1;
            send_beat(words[i][15:0], r.rdy_mode != 0);
            restart = 1'b0;
            send_beat(words[i][31:16], r.rdy_mode != 0);
        end
        wait_done();
        check("n_writes", got_q.size(), r.nwrites);
        check("beats", beats_acc, 5 + 2 * (ni + nd));
        for (int i = 0; i < exp.size() && i < got_q.size(); i++)
            check($sformatf("write%0d", i), got_q[i], exp[i]);
        if (got_q.size() == r.nwrites) begin
            check("first_data_addr", got_q[ni][43:32], r.first_addr);
            check("last_data_addr", got_q[ni + nd - 1][43:32], r.last_addr);
            if (!r.ones) check("word0", got_q[0], {1'b0, 12'h000, 32'hDEADBEEF});
        end
`ifdef LOADER_CHECKSUM_EN
        check("checksum", checksum, xsum);
        if (r.ones) check("checksum_ones", checksum, 32'h0);
`endif
        acc0 = beats_acc;
        n0   = got_q.size();
        bus.in_data = 16'h5555;
        bus.in_vld  = 1'b1;
        repeat (3) tick();
        check("done_in_rdy", bus.in_rdy, 0);
        bus.in_vld = 1'b0;
        check("done_ignores_beats", beats_acc, acc0);
        check("done_no_writes", got_q.size(), n0);
        prev_il = r.cfg[0];
    endtask

    initial begin
        logic [31:0] sw[6];
        logic [44:0] sexp[6];
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        rows[0] = mk_row(16'd125, 16'd23, 16'h07D0, 16'd23, 16'h07E8, 0, 0, 0, 12'h7D0, 12'h7E7, 150);
        rows[1] = mk_row(16'd3, 16'd3, 16'h0FFE, 16'd7, 16'h0100, 0, 1, 1, 12'hFFE, 12'h001, 8);
        rows[2] = mk_row(16'd0, 16'd0, 16'h1234, 16'd0, 16'h0000, 0, 0, 1, 12'h234, 12'h234, 2);
        rows[3] = mk_row(16'd125, 16'd23, 16'h07D0, 16'd23, 16'h07E8, 1, 0, 1, 12'h7D0, 12'h7E7, 150);

        bus.in_vld  = 1'b0;
        bus.in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", bus.in_rdy, 0);
        check("rst_wr_vld", bus.wr_vld, 0);
        check("rst_wr_sel", bus.wr_sel, 0);
        check("rst_wr_addr", bus.wr_addr, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_cfg", {cfg_il, cfg_inl, cfg_ib, cfg_ol, cfg_ob}, 0);
        check("rst_load_done", load_done, 0);
`ifdef LOADER_CHECKSUM_EN
        check("rst_checksum", checksum, 0);
`endif
        rst_n = 1'b1;
        tick();
        check("in_rdy_after_reset", bus.in_rdy, 1);
        chk_rdy = 1;

        rdy_mode   = 2;
        rdy_manual = 1'b0;
        got_q.delete();
        beats_acc = 0;
        exp_total = 6;
        for (int i = 0; i < 6; i++) sw[i] = $urandom();
        for (int i = 0; i < 4; i++) sexp[i] = {1'b0, 12'(i), sw[i]};
        sexp[4] = {1'b1, 12'h100, sw[4]};
        sexp[5] = {1'b1, 12'h101, sw[5]};
        send_beat(16'd3, 0);
        send_beat(16'd1, 0);
        send_beat(16'h0100, 0);
        send_beat(16'd0, 0);
        send_beat(16'd0, 0);
        send_beat(sw[0][15:0], 0);
        send_beat(sw[0][31:16], 0);
        bus.in_data = sw[1][15:0];
        bus.in_vld  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("stall_in_rdy", bus.in_rdy, 0);
            check("stall_wr_vld", bus.wr_vld, 1);
            check("stall_word", {bus.wr_sel, bus.wr_addr, bus.wr_data}, sexp[0]);
        end
        tick();
        check("stall_no_write", got_q.size(), 0);
        rdy_manual = 1'b1;
        send_beat(sw[1][15:0], 0);
        send_beat(sw[1][31:16], 0);
        for (int i = 2; i < 6; i++) begin
            send_beat(sw[i][15:0], 0);
            send_beat(sw[i][31:16], 0);
        end
        wait_done();
        check("stall_n_writes", got_q.size(), 6);
        check("stall_beats", beats_acc, 17);
        for (int i = 0; i < 6 && i < got_q.size(); i++)
            check($sformatf("stall_write%0d", i), got_q[i], sexp[i]);
        prev_il = 16'd3;

        for (int r = 0; r < 4; r++) run_load(rows[r]);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        rdy_mode  = 0;
        exp_total = 99999;
        for (int k = 0; k < 5; k++) send_beat(rows[0].cfg[k], 0);
        for (int i = 0; i < 10; i++) begin
            send_beat(16'hAAAA, 0);
            send_beat(16'h5555, 0);
        end
        send_beat(16'h0BAD, 0);
        chk_rdy = 0;
        rst_n   = 1'b0;
        #1;
        check("midrst_wr_vld", bus.wr_vld, 0);
        check("midrst_in_rdy", bus.in_rdy, 0);
        check("midrst_cfg", cfg_il, 0);
        check("midrst_load_done", load_done, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midrst_in_rdy_after", bus.in_rdy, 1);
        chk_rdy = 1;
        run_load(rows[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
